uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
- Shares one UART byte transmitter between two requesters: port 0 is the CPU peripheral write path, port 1 is the debug/echo path.
- Round-robin arbitration; at most one byte is in flight at a time.
- Drives the transmitter's one-cycle enable pulse and holds the data byte stable for the whole frame.
- Sequences on the transmitter's status line (1 = idle, 0 = busy).

Parameters:
- BUSY_TIMEOUT, 16, clk cycles to wait after tx_en for tx_status to fall before flagging an error.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > BUSY_TIMEOUT.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester byte valid; bit i = requester i.
- req_data0  in  8  requester 0 byte.
- req_data1  in  8  requester 1 byte.
- req_ready  out  2  per-requester accept; transfer occurs when valid & ready in the same cycle.
- req_done  out  2  one-cycle pulse to the owning requester when its frame completes.
- tx_en  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to the transmitter; stable from the tx_en cycle until the frame completes.
- tx_status  in  1  transmitter status: 1 = idle, 0 = sending.
- err_timeout  out  1  sticky flag: the transmitter never went busy; cleared only by reset.
- owner  out  1  index of the requester granted last or currently.

Behaviour:
- Reset values: req_ready=00, req_done=00, tx_en=0, tx_data=8'h00, err_timeout=0, owner=1. With owner=1, the first grant on a tie goes to requester 0. State goes to IDLE and the timeout counter to 0.
- States are IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - req_ready is combinational: the bit of the requester that would win this cycle, and only when tx_status=1. Otherwise 00.
  - Winner: if exactly one valid, that one. If both valid, the requester != owner.
  - On accept: latch tx_data from the winner, set owner, go to LAUNCH.
  - If tx_status=0 in IDLE (transmitter busy externally), grant nothing.
- LAUNCH: tx_en=1 for exactly this cycle. Clear the counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_status=0, go to WAIT_DONE.
  - Else increment the counter. When the counter reaches BUSY_TIMEOUT: set err_timeout, pulse req_done[owner], go to IDLE. There is no retry.
- WAIT_DONE:
  - Hold tx_data.
  - On tx_status=1: pulse req_done[owner] for 1 cycle, go to IDLE.
- Latency: accept cycle N; tx_en in cycle N+1; the earliest next accept is the cycle after the done pulse.
- Only one byte is ever in flight. tx_en is never asserted outside LAUNCH.
- A requester dropping valid without being accepted is legal. Its data is not sampled.
- Simultaneous events:
  - Done pulse and a new request in the same cycle: the new request is not accepted until IDLE in the next cycle.
  - A timeout and a tx_status fall in the same cycle: the fall wins (go to WAIT_DONE, no error).
- Reset mid-frame: returns to IDLE immediately with all outputs at reset values. No done pulse is issued. The transmitter's own reset is the system's responsibility.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...

Decomposition:
- Shared package holds the state encoding constants: IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3.
- The package also holds the requester index constants REQ_CPU=0 and REQ_DBG=1.
- One sub-module, rr_arb2: a 2-way round-robin grant from (valid, owner, enable) producing a one-hot grant. It is combinational plus the owner register.
- The FSM, data latch and timeout counter live in the top.

Test Plan:
- Single request: req_valid=01, data0=8'hA5, tx_status model goes low 1 cycle after tx_en and high 160 cycles later.
  - Required: ready[0] for 1 cycle, tx_en one cycle later, tx_data=A5 held throughout, req_done=01 one cycle after tx_status rises.
- Contention: both valid from reset, data0=8'h11, data1=8'h22, held valid.
  - Required: tx_data sequence 11,22,11,22, with owner alternating.
- Busy-external: tx_status=0 while req_valid=10.
  - Required: req_ready stays 00 until tx_status=1, then ready=10.
- Timeout: the transmitter model ignores tx_en (status stays 1).
  - Required: after BUSY_TIMEOUT=16 cycles in WAIT_BUSY, err_timeout=1 (sticky), req_done=01 pulse, back to IDLE and accepting.
- Reset mid-frame: assert reset during WAIT_DONE.
  - Required: next cycle tx_en=0, tx_data=00, req_done=00, req_ready=00. The first post-reset tie goes to requester 0.
- Simultaneous timeout boundary: tx_status falls on the exact cycle the counter reaches 16.
  - Required: no err_timeout, normal completion with done pulse.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared encodings for the UART transmit scheduler: FSM states, requester
// indices and a one-hot helper used by the top and the round-robin arbiter.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered owner.
// On a tie the requester that did not win last time is granted.
module rr_arb2
    import uart_tx_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid_i,
    input  logic       enable_i,
    output logic [1:0] grant_o,
    output logic       owner_o
);

    logic owner_q;
    logic owner_d;

    always_comb begin
        grant_o = 2'b00;
        if (enable_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = req_onehot(~owner_q);
                default: grant_o = 2'b00;
            endcase
        end
    end

    // A grant is only ever issued to a valid requester, so a grant is a transfer.
    always_comb begin
        owner_d = owner_q;
        if (grant_o[REQ_DBG]) begin
            owner_d = 1'b1;
        end else if (grant_o[REQ_CPU]) begin
            owner_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= 1'b1;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign owner_o = owner_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter between the CPU and debug requesters, one byte
// in flight; accept at N, tx_en at N+1, next accept no earlier than after req_done.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int BUSY_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic [1:0] req_done,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_status,
    output logic       err_timeout,
    output logic       owner
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [7:0]       data_q, data_d;
    logic             err_q, err_d;
    logic [1:0]       done_q, done_d;
    logic             arb_en;
    logic [1:0]       grant;
    logic             owner_cur;

    // No grant during the done-pulse cycle, so the next accept lands one cycle later.
    assign arb_en  = (state_q == IDLE) & tx_status & ~(|done_q) & ~reset;
    assign cnt_inc = cnt_q + CNT_ONE;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (req_valid),
        .enable_i (arb_en),
        .grant_o  (grant),
        .owner_o  (owner_cur)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        done_d  = 2'b00;
        tx_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    data_d  = grant[REQ_DBG] ? req_data1 : req_data0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_en   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A falling status beats a timeout landing in the same cycle.
                if (!tx_status) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT_CNT) begin
                        err_d   = 1'b1;
                        done_d  = req_onehot(owner_cur);
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_status) begin
                    done_d  = req_onehot(owner_cur);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= 8'h00;
            err_q   <= 1'b0;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign req_ready   = grant;
    assign req_done    = done_q;
    assign tx_data     = data_q;
    assign err_timeout = err_q;
    assign owner       = owner_cur;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized and directed bench for uart_tx_scheduler against a cycle-count model
// of frame timing, with a simple transmitter model driving tx_status.
module tb_uart_tx_scheduler;

    localparam int BUSY_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic [1:0] req_done;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_status;
    logic       err_timeout;
    logic       owner;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .CNT_W        (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .req_done    (req_done),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_status   (tx_status),
        .err_timeout (err_timeout),
        .owner       (owner)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // transmitter model controls
    int   tx_dly   = 1;
    int   tx_len   = 8;
    logic tx_ign   = 1'b0;
    logic ext_busy = 1'b0;
    logic rnd_tx   = 1'b0;

    logic [7:0] en_data_q[$];
    logic       en_owner_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] winner(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // Reference: a frame is described by its launch cycle and whether busy was seen.
    logic       m_owner, m_err, m_inflight, m_fell, m_done_who;
    logic [7:0] m_data;
    int         m_launch, m_done_cyc;

    initial begin
        logic [1:0] exp_rdy;
        logic [1:0] exp_done;
        m_owner = 1'b1; m_err = 1'b0; m_inflight = 1'b0; m_fell = 1'b0;
        m_data = 8'h00; m_launch = 0; m_done_cyc = -1; m_done_who = 1'b0;
        forever begin
            @(negedge clk);
            exp_rdy  = (!reset && !m_inflight && cyc != m_done_cyc && tx_status)
                       ? winner(req_valid, m_owner) : 2'b00;
            exp_done = (cyc == m_done_cyc) ? (m_done_who ? 2'b10 : 2'b01) : 2'b00;
            if (cyc > 0) begin
                check("req_ready", 32'(req_ready), 32'(exp_rdy));
                check("tx_en", 32'(tx_en), 32'(m_inflight && cyc == m_launch));
                check("tx_data", 32'(tx_data), 32'(m_data));
                check("req_done", 32'(req_done), 32'(exp_done));
                check("err_timeout", 32'(err_timeout), 32'(m_err));
                check("owner", 32'(owner), 32'(m_owner));
            end
            if (tx_en === 1'b1) begin
                en_data_q.push_back(tx_data);
                en_owner_q.push_back(owner);
            end
            @(posedge clk);
            if (reset) begin
                m_owner = 1'b1; m_err = 1'b0; m_inflight = 1'b0; m_fell = 1'b0;
                m_data = 8'h00; m_done_cyc = -1;
            end else if (!m_inflight) begin
                if (exp_rdy != 2'b00) begin
                    m_data     = exp_rdy[1] ? req_data1 : req_data0;
                    m_owner    = exp_rdy[1];
                    m_inflight = 1'b1;
                    m_launch   = cyc + 1;
                    m_fell     = 1'b0;
                end
            end else if (cyc > m_launch) begin
                if (!m_fell) begin
                    if (!tx_status) begin
                        m_fell = 1'b1;
                    end else if (cyc - m_launch == BUSY_TIMEOUT) begin
                        m_err = 1'b1;
                        m_done_cyc = cyc + 1; m_done_who = m_owner; m_inflight = 1'b0;
                    end
                end else if (tx_status) begin
                    m_done_cyc = cyc + 1; m_done_who = m_owner; m_inflight = 1'b0;
                end
            end
            cyc++;
        end
    end

    // Transmitter: goes busy dly cycles after tx_en, stays busy len cycles.
    initial begin
        int   fall_cd, busy_cd, dly, len;
        logic ign, st, en_s, rst_s, ext_s, rnd_s;
        fall_cd = 0; busy_cd = 0; dly = 1; len = 1; ign = 1'b0; st = 1'b1;
        tx_status = 1'b1;
        forever begin
            @(negedge clk);
            en_s = tx_en; rst_s = reset; ext_s = ext_busy; rnd_s = rnd_tx;
            @(posedge clk);
            #1;
            if (rst_s) begin
                fall_cd = 0; busy_cd = 0; st = 1'b1;
            end else begin
                if (en_s === 1'b1) begin
                    if (rnd_s) begin
                        ign = ($urandom_range(0, 5) == 0);
                        dly = $urandom_range(1, 18);
                        len = $urandom_range(1, 12);
                    end else begin
                        ign = tx_ign; dly = tx_dly; len = tx_len;
                    end
                    if (!ign) fall_cd = dly;
                end
                if (fall_cd > 0) begin
                    fall_cd--;
                    if (fall_cd == 0) begin
                        st = 1'b0;
                        busy_cd = len;
                    end
                end else if (busy_cd > 0) begin
                    busy_cd--;
                    if (busy_cd == 0) st = 1'b1;
                end
            end
            tx_status = ext_s ? 1'b0 : st;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, output int c, output logic [1:0] d);
        logic got;
        got = 1'b0; c = -1; d = 2'b00;
        for (int n = 0; n < limit && !got; n++) begin
            @(negedge clk);
            if (req_done != 2'b00) begin
                got = 1'b1; c = cyc; d = req_done;
            end
            tick();
        end
        check("done_seen_in_bound", 32'(got), 1);
    endtask

    initial begin
        int         c_en, c_dn;
        logic [1:0] d;
        reset = 1'b1; req_valid = 2'b00; req_data0 = 8'h00; req_data1 = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_tx_en", 32'(tx_en), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_done", 32'(req_done), 0);
        check("rst_err", 32'(err_timeout), 0);
        check("rst_owner", 32'(owner), 1);
        tick();

        // single request, 160-cycle frame
        tx_dly = 1; tx_len = 160;
        req_data0 = 8'hA5; req_valid = 2'b01;
        @(negedge clk); check("single_ready", 32'(req_ready), 1);
        tick(); req_valid = 2'b00;
        @(negedge clk);
        check("single_tx_en", 32'(tx_en), 1);
        check("single_tx_data", 32'(tx_data), 'hA5);
        c_en = cyc;
        tick();
        wait_done(400, c_dn, d);
        check("single_done", 32'(d), 1);
        check("single_latency", 32'(c_dn - c_en), 162);
        tick();

        // transmitter busy externally
        tx_len = 5; ext_busy = 1'b1;
        tick();
        req_data1 = 8'h5A; req_valid = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); check("ext_busy_ready", 32'(req_ready), 0);
            tick();
        end
        ext_busy = 1'b0;
        tick();
        @(negedge clk); check("ext_release_ready", 32'(req_ready), 2);
        tick(); req_valid = 2'b00;
        wait_done(100, c_dn, d);
        check("ext_done", 32'(d), 2);
        tick();

        // transmitter ignores tx_en
        tx_ign = 1'b1; req_data0 = 8'h3C; req_valid = 2'b01;
        @(negedge clk); check("to_ready", 32'(req_ready), 1);
        tick();
        @(negedge clk); c_en = cyc; check("to_tx_en", 32'(tx_en), 1);
        tick();
        wait_done(100, c_dn, d);
        check("to_done", 32'(d), 1);
        check("to_latency", 32'(c_dn - c_en), 17);
        check("to_err", 32'(err_timeout), 1);
        @(negedge clk); check("to_reaccept", 32'(req_ready), 1);
        tx_ign = 1'b0; tx_len = 4;
        tick(); req_valid = 2'b00;
        wait_done(100, c_dn, d);
        check("to_err_sticky", 32'(err_timeout), 1);
        tick();

        // reset during WAIT_DONE
        tx_len = 40; req_data0 = 8'h77; req_valid = 2'b01;
        tick(); req_valid = 2'b00;
        repeat (10) tick();
        reset = 1'b1; req_valid = 2'b11; req_data1 = 8'h88;
        tick();
        @(negedge clk);
        check("mid_rst_tx_en", 32'(tx_en), 0);
        check("mid_rst_tx_data", 32'(tx_data), 0);
        check("mid_rst_done", 32'(req_done), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        check("mid_rst_err", 32'(err_timeout), 0);
        tick(); reset = 1'b0;
        @(negedge clk); check("post_rst_tie", 32'(req_ready), 1);
        tick(); req_valid = 2'b00;
        wait_done(100, c_dn, d);
        check("post_rst_done", 32'(d), 1);
        tick();

        // busy falls exactly when the timeout would fire
        tx_dly = 16; tx_len = 5; req_data1 = 8'h99; req_valid = 2'b10;
        @(negedge clk); check("bnd_ready", 32'(req_ready), 2);
        tick(); req_valid = 2'b00;
        @(negedge clk); c_en = cyc;
        tick();
        wait_done(100, c_dn, d);
        check("bnd_done", 32'(d), 2);
        check("bnd_latency", 32'(c_dn - c_en), 22);
        check("bnd_no_err", 32'(err_timeout), 0);
        tick();

        // contention from reset
        reset = 1'b1; tx_dly = 1; tx_len = 8;
        req_data0 = 8'h11; req_data1 = 8'h22; req_valid = 2'b11;
        tick(); tick();
        reset = 1'b0;
        en_data_q.delete(); en_owner_q.delete();
        for (int n = 0; n < 300 && en_data_q.size() < 4; n++) tick();
        check("cont_frames", 32'(en_data_q.size() >= 4), 1);
        if (en_data_q.size() >= 4) begin
            check("cont_data0", 32'(en_data_q[0]), 'h11);
            check("cont_data1", 32'(en_data_q[1]), 'h22);
            check("cont_data2", 32'(en_data_q[2]), 'h11);
            check("cont_data3", 32'(en_data_q[3]), 'h22);
            check("cont_owner0", 32'(en_owner_q[0]), 0);
            check("cont_owner1", 32'(en_owner_q[1]), 1);
            check("cont_owner2", 32'(en_owner_q[2]), 0);
            check("cont_owner3", 32'(en_owner_q[3]), 1);
        end
        req_valid = 2'b00;
        repeat (30) tick();

        // random traffic
        rnd_tx = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_data0 = 8'($urandom);
            req_data1 = 8'($urandom);
            ext_busy  = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0; ext_busy = 1'b0; req_valid = 2'b00; rnd_tx = 1'b0;
        repeat (50) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
